// File: rtl/dpi_stream_pkg.sv
// Purpose: shared widths and FSM state codes for the DPI stream sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpi_stream_pkg;

    localparam int SID_W       = 6;
    localparam int NUM_STREAMS = 64;
    localparam int CNT_W       = 8;

    // FSM state codes
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

endpackage

// File: rtl/dpi_flow_cam.sv
// Purpose: 64-entry flow-key CAM; lowest-index hit, else allocate round-robin.
// Latency: combinational match; allocation is written on the lookup edge.
// Backpressure: none; a lookup is presented for exactly one cycle.
module dpi_flow_cam
    import dpi_stream_pkg::*;
#(
    parameter int KEY_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [SID_W-1:0] sid_o,
    output logic             new_o
);

    logic [KEY_W-1:0]       key_q [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] vld_q;
    logic [SID_W-1:0]       alloc_ptr_q;
    logic [NUM_STREAMS-1:0] match;
    logic                   hit;
    logic [SID_W-1:0]       hit_idx;

    // Parallel compare against every valid entry
    always_comb begin
        for (int i = 0; i < NUM_STREAMS; i++) begin
            match[i] = vld_q[i] && (key_q[i] == key_i);
        end
    end

    // Priority encode: scanning downwards lets the lowest matching index win
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = SID_W'(i);
            end
        end
    end

    assign sid_o = hit ? hit_idx : alloc_ptr_q;
    assign new_o = ~hit;

    // Valid bits and allocation pointer; the pointer wraps so the oldest entry is reused
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            alloc_ptr_q <= '0;
        end else if (lookup_i && !hit) begin
            vld_q[alloc_ptr_q] <= 1'b1;
            alloc_ptr_q        <= alloc_ptr_q + 1'b1;
        end
    end

    // Key storage needs no reset: entries are qualified by vld_q
    always_ff @(posedge clk) begin
        if (lookup_i && !hit) begin
            key_q[alloc_ptr_q] <= key_i;
        end
    end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Purpose: map flow key to stream id and sequence load_state/wait/payload/eop to the regex wrappers.
// Latency: load_state 2 cycles after sop is seen; first char LOAD_WAIT later; eop EOP_DELAY after last char.
// Backpressure: sop byte held (in_ready=0) until STREAM; stray non-sop bytes in IDLE are accepted and dropped.
module dpi_stream_sequencer
    import dpi_stream_pkg::*;
#(
    parameter int KEY_W     = 32,
    parameter int LOAD_WAIT = 2,
    parameter int EOP_DELAY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [7:0]       in_data,
    input  logic [KEY_W-1:0] in_key,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic             cfg_en,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             load_state,
    output logic [5:0]       stream_id,
    output logic             new_stream_id,
    output logic             eop,
    output logic             enable
);

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0]       key_q;
    logic [SID_W-1:0]       sid_q;
    logic                   new_q;
    logic                   enable_q;
    logic [NUM_STREAMS-1:0] en_table_q;
    logic [SID_W-1:0]       cam_sid;
    logic                   cam_new;
    logic                   drain_done;

    dpi_flow_cam #(.KEY_W(KEY_W)) u_cam (
        .clk      (clk),
        .rst_n    (rst_n),
        .lookup_i (state_q == S_LOOKUP),
        .key_i    (key_q),
        .sid_o    (cam_sid),
        .new_o    (cam_new)
    );

    assign drain_done = (state_q == S_DRAIN) && (cnt_q == CNT_W'(EOP_DELAY - 1));

    // Next-state and wait/drain counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_sop) state_d = S_LOOKUP;
            end
            S_LOOKUP: state_d = S_LOAD;
            S_LOAD: begin
                cnt_d   = '0;
                state_d = (LOAD_WAIT > 1) ? S_WAIT : S_STREAM;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(LOAD_WAIT - 2)) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (in_valid && in_eop) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register; reset aborts any packet in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-packet context: key at sop, stream id at lookup, enable at load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q    <= '0;
            sid_q    <= '0;
            new_q    <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && in_valid && in_sop) key_q <= in_key;
            if (state_q == S_LOOKUP) begin
                sid_q <= cam_sid;
                new_q <= cam_new;
            end
            if (state_q == S_LOAD) enable_q <= en_table_q[sid_q];
        end
    end

    // Regex-enable table, writable at any time; only sampled at LOAD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_table_q <= '1;
        end else if (cfg_we) begin
            en_table_q[cfg_addr] <= cfg_en;
        end
    end

    assign in_ready      = ((state_q == S_IDLE) && in_valid && !in_sop) || (state_q == S_STREAM);
    assign char_in_vld   = (state_q == S_STREAM) && in_valid;
    assign char_in       = (state_q == S_STREAM) ? in_data : 8'h00;
    assign load_state    = (state_q == S_LOAD);
    assign eop           = drain_done;
    assign stream_id     = sid_q;
    assign new_stream_id = new_q;
    // During LOAD the table value is shown directly so enable is valid alongside load_state
    assign enable        = (state_q == S_LOAD) ? en_table_q[sid_q] : enable_q;

endmodule
